// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector, valid/ready load side.
// Define SEQ_SER_MSB_FIRST_EN to send bit WIDTH-1 first instead of bit 0.
module seq_bit_serializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             done_q, done_d;

    logic             last_step;
    logic             accept;
    logic [WIDTH-1:0] shifted;
    logic             head_bit;

    // Handshake: accept when idle, or exactly as the last bit is consumed.
    always_comb begin
        last_step  = (state_q == SHIFT) && ser_en && (cnt_q == LAST);
        load_ready = (state_q == IDLE) || last_step;
        accept     = load_valid && load_ready;
    end

    // Next state, shift register, bit index and registered serial bit.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        ser_out_d = 1'b0;
`ifdef SEQ_SER_MSB_FIRST_EN
        shifted = shreg_q << 1;
`else
        shifted = shreg_q >> 1;
`endif
        if (accept) begin
            shreg_d = load_data;
            cnt_d   = '0;
            state_d = SHIFT;
            done_d  = last_step;
        end else if (state_q == SHIFT && ser_en) begin
            if (cnt_q == LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
`ifdef SEQ_SER_MSB_FIRST_EN
        head_bit = shreg_d[WIDTH-1];
`else
        head_bit = shreg_d[0];
`endif
        if (state_d == SHIFT) begin
            ser_out_d = head_bit;
        end
    end

    // State register; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ser_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            ser_out_q <= ser_out_d;
            done_q    <= done_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        ser_out    = ser_out_q;
        ser_valid  = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        frame_done = done_q;
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: random traffic against a bit-queue model.
// Build with SEQ_SER_MSB_FIRST_EN to exercise the MSB-first variant.
module tb_seq_bit_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         ser_en;
    logic         ser_out;
    logic         ser_valid;
    logic         frame_done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    bit q[$];
    bit exp_done = 1'b0;

    seq_bit_serializer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ser_en     (ser_en),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model's outstanding-bit queue.
    task automatic chk_outs();
        chk("ser_valid", ser_valid, q.size() > 0);
        chk("busy", busy, q.size() > 0);
        chk("frame_done", frame_done, exp_done);
        chk("ser_out", ser_out, (q.size() > 0) ? q[0] : 1'b0);
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input logic lv, input logic [W-1:0] ld,
                       input logic en, output logic acc);
        bit exp_rdy;
        load_valid = lv;
        load_data  = ld;
        ser_en     = en;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && en);
        chk("load_ready", load_ready, exp_rdy);
        acc      = lv && exp_rdy;
        exp_done = en && (q.size() == 1);
        if (en && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            for (int i = 0; i < W; i++) begin
`ifdef SEQ_SER_MSB_FIRST_EN
                q.push_back(ld[W-1-i]);
`else
                q.push_back(ld[i]);
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk_outs();
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic mid_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", ser_valid, 1'b0);
        chk("rst_out", ser_out, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        q.delete();
        exp_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic         acc;
        logic         have;
        logic [W-1:0] data;
        int           n;

        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        ser_en     = 1'b0;
        @(negedge clk);
        chk_outs();
        rst = 1'b0;

        // Single frame at full rate.
        cyc(1'b1, 16'b1011011011011011, 1'b1, acc);
        chk("single_acc", acc, 1'b1);
        for (int i = 0; i < W + 2; i++) cyc(1'b0, '0, 1'b1, acc);

        // Stall after bit 4.
        cyc(1'b1, 16'b1011011011011011, 1'b1, acc);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, acc);
        for (int i = 0; i < W; i++) cyc(1'b0, '0, 1'b1, acc);

        // Back-to-back frames with no bubble.
        cyc(1'b1, 16'hFFFF, 1'b1, acc);
        n = 0;
        do begin
            cyc(1'b1, 16'h0000, 1'b1, acc);
            n++;
        end while (!acc && n < 40);
        chk("b2b_handoff", n, W);
        for (int i = 0; i < W + 2; i++) cyc(1'b0, '0, 1'b1, acc);

        // Reset after bit 7, then restart.
        cyc(1'b1, 16'hA5C3, 1'b1, acc);
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, acc);
        mid_reset();
        cyc(1'b0, '0, 1'b1, acc);
        cyc(1'b1, 16'h8001, 1'b1, acc);
        for (int i = 0; i < W + 2; i++) cyc(1'b0, '0, 1'b1, acc);

        // Random traffic; the source holds data until accepted.
        have = 1'b0;
        data = '0;
        for (int i = 0; i < 4000; i++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                data = W'($urandom);
            end
            cyc(have, data, (i % 1000 < 500) ? 1'b1
                                             : ($urandom_range(0, 2) != 0),
                acc);
            if (acc) have = 1'b0;
            if ($urandom_range(0, 499) == 0) mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial sequence-detector stage: accepts a parallel word via valid/ready handshake and presents it one bit per accepted step on a single serial line.
- ser_out drives the detector's serial input; ser_en is the step strobe shared with the detector's clock-enable/advance.
- Back-to-back frames stream with no bubble, so patterns straddling word boundaries reach the detector intact.

Parameters:
- WIDTH, 16, bits per frame (>=2).
- CNT_W, 5, bit-index counter width; must satisfy 2**CNT_W > WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- load_valid  input  1  load_data holds a frame.
- load_ready  output  1  serializer can accept a frame this cycle.
- load_data  input  WIDTH  parallel frame; bit 0 is sent first (default build).
- ser_en  input  1  consume current serial bit at this edge.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a frame bit.
- frame_done  output  1  one-cycle pulse after the last bit of a frame is consumed.
- busy  output  1  state == SHIFT.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, cnt=0, ser_out=0, ser_valid=0, frame_done=0, busy=0. Takes effect immediately, even mid-frame; the partial frame is discarded and no frame_done is issued.
- States: IDLE, SHIFT.
- load_ready (combinational): 1 in IDLE; in SHIFT, 1 only when cnt==WIDTH-1 and ser_en==1. Otherwise 0.
- A load is accepted at an edge with load_valid & load_ready.
  - Shift register <= load_data, cnt <= 0, state <= SHIFT.
  - load_data is ignored at every other edge.
- IDLE: ser_valid=0 and ser_out=0. ser_en is ignored.
- SHIFT: ser_valid=1 and ser_out=shreg[0] (registered, glitch-free).
  - ser_en=0: hold the shift register, cnt and ser_out.
  - ser_en=1 and cnt<WIDTH-1: shift right by one, cnt <= cnt+1.
  - ser_en=1 and cnt==WIDTH-1 (last bit): frame_done <= 1 for the next cycle only.
    - If a load is accepted at the same edge: reload, cnt <= 0, stay in SHIFT. This is a zero-bubble handoff.
    - Otherwise: state <= IDLE, ser_valid <= 0, ser_out <= 0.
- Latency: load accepted at edge N puts bit 0 on ser_out during cycle N+1. With ser_en held at 1, bit k appears in cycle N+1+k and frame_done is high in cycle N+1+WIDTH.
- frame_done is 0 in all cycles other than those described above.
- load_valid with no acceptance: no state change. The upstream source must hold the data until load_ready.

Optional Feature:
- Macro: SEQ_SER_MSB_FIRST_EN.
- Defined:
  - ser_out = shreg[WIDTH-1].
  - The register shifts left on consume.
  - Bit WIDTH-1 is sent first.
  - All handshake, cnt and frame_done timing is identical to the default build.
- Undefined: LSB-first as above.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately; load_ready=1 after release.
- Single frame: load 16'b1011011011011011, ser_en=1 constant -> ser_out over cycles 1..16 = 1,1,0,1,1,0,1,1,0,1,1,0,1,1,0,1; frame_done=1 in cycle 17 only; ser_valid=0 and busy=0 from cycle 17.
- Stall: same frame, ser_en=0 for 3 cycles after bit 4 -> ser_out holds 1 for 4 cycles; remaining order unchanged; frame_done is delayed by 3 cycles.
- Back-to-back: load_valid held with 16'hFFFF then 16'h0000 -> 16 ones then 16 zeros with no ser_valid gap; load_ready pulses only on the last-bit cycle; frame_done pulses at cycle 17 and cycle 33.
- Mid-frame reset: rst=1 after bit 7 -> ser_valid=0 at once and no frame_done pulse; next load restarts at bit 0.
- MSB-first build: load 16'h8001 -> ser_out = 1, fourteen 0s, 1; same frame_done timing as the default build.
